bomberman_control: RTL and testbench

- Frame scheduler FSM that sequences bomberman_datapath.
- Each frame it:
  - redraws the 11x11 tile field (with explosions),
  - redraws active bombs,
  - runs the four-corner collision/damage check for each player,
  - draws players and hearts, then commits the frame (print_screen).
- Generates the per-frame `refresh` strobe that steps player coordinates.
- Detects game over, shows the end screen, and waits for `start` to restart.

---
 rtl/bomberman_pkg.sv | 57 +++++
 rtl/bomberman_control_frame_timer.sv | 30 +++
 rtl/bomberman_control.sv | 267 ++++++++++++++++++++++++++
 tb/tb_bomberman_control.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bomberman_pkg.sv
// Shared constants and types for the bomberman frame scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bomberman_pkg;

  localparam int TILES_PER_SIDE = 11;

  // Source ROM selection presented to the copy engine
  typedef enum logic [1:0] {
    MEM_STAGE    = 2'd0,
    MEM_TILE     = 2'd1,
    MEM_SPRITE   = 2'd2,
    MEM_GAMEOVER = 2'd3
  } mem_sel_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'd0,
    WIN_P1   = 2'd1,
    WIN_P2   = 2'd2,
    WIN_DRAW = 2'd3
  } winner_e;

  typedef enum logic [4:0] {
    ST_IDLE,
    ST_STAGE,
    ST_TILES,
    ST_TC_STEP,
    ST_TC_CHECK,
    ST_BOMBS,
    ST_CHK_P1,
    ST_DRAW_P1,
    ST_HP_P1,
    ST_CHK_P2,
    ST_DRAW_P2,
    ST_HP_P2,
    ST_COMMIT,
    ST_WAIT_TICK,
    ST_OVER,
    ST_OVER_COMMIT,
    ST_WAITREL
  } state_e;

  // Sub-phase of a single copy handshake
  typedef enum logic [1:0] {
    PH_LOAD,
    PH_GO,
    PH_WAIT
  } copy_phase_e;

  // A dead player hands the win to the other one: {p1_dead, p2_dead}
  // gives 1 when only P2 died, 2 when only P1 died, 3 for a draw.
  function automatic logic [1:0] winner_code(input logic [1:0] p1_lives,
                                             input logic [1:0] p2_lives);
    return {p1_lives == 2'd0, p2_lives == 2'd0};
  endfunction

endpackage

// File: rtl/bomberman_control_frame_timer.sv
// Free-running frame period counter producing a one-cycle tick at wrap.
// Latency: tick is high on the last count of each FRAME_CYCLES period.
// Backpressure: none; counts every cycle regardless of consumer.
module frame_timer #(
  parameter int FRAME_CYCLES = 833333
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int            CW   = $clog2(FRAME_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(FRAME_CYCLES - 1);

  logic [CW-1:0] count;

  assign tick = (count == LAST);

  // Count 0..FRAME_CYCLES-1 and wrap
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/bomberman_control.sv
// Per-frame scheduler sequencing field, bombs, collision checks, players and hearts.
// Latency: each draw item is LOAD, copy_enable, then waits for finished; frame commit then waits for tick.
// Backpressure: stalls in the copy wait until finished; never reissues copy_enable before it.
module bomberman_control
  import bomberman_pkg::*;
#(
  parameter int FRAME_CYCLES = 833333,
  parameter int NUM_BOMBS    = 8,
  parameter int CHECK_HOLD   = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       finished,
  input  logic       all_tiles_drawn,
  input  logic [1:0] p1_lives,
  input  logic [1:0] p2_lives,
  output logic       copy_enable,
  output logic [1:0] memory_select,
  output logic       tc_enable,
  output logic       player_reset,
  output logic       tile_reset,
  output logic       draw_stage,
  output logic       draw_explosion,
  output logic       draw_bomb,
  output logic       draw_p1,
  output logic       draw_p1_hp,
  output logic       draw_p2,
  output logic       draw_p2_hp,
  output logic       check_p1,
  output logic       check_p2,
  output logic [1:0] corner_id,
  output logic [2:0] bomb_id,
  output logic [1:0] p1_hp_id,
  output logic [1:0] p2_hp_id,
  output logic       refresh,
  output logic       print_screen,
  output logic [1:0] winner
);

  localparam logic [2:0] LAST_BOMB = 3'(NUM_BOMBS - 1);
  localparam logic [7:0] LAST_HOLD = 8'(CHECK_HOLD - 1);

  state_e      state, state_n;
  copy_phase_e phase, phase_n;
  logic [2:0]  bomb_n;
  logic [1:0]  corner_n, hp1_n, hp2_n, winner_n;
  logic [7:0]  hold_cnt, hold_n;
  logic        chk_gap, gap_n;
  logic        tick, tick_pend, pend_n;
  logic        copy_state, load, copy_done;

  frame_timer #(.FRAME_CYCLES(FRAME_CYCLES)) u_frame_timer (
    .clock (clock),
    .reset (reset),
    .tick  (tick)
  );

  // Next-state, handshake sequencing and strobe decode
  always_comb begin
    state_n        = state;
    phase_n        = phase;
    bomb_n         = bomb_id;
    corner_n       = corner_id;
    hp1_n          = p1_hp_id;
    hp2_n          = p2_hp_id;
    hold_n         = hold_cnt;
    gap_n          = chk_gap;
    winner_n       = winner;
    copy_enable    = 1'b0;
    memory_select  = MEM_STAGE;
    tc_enable      = 1'b0;
    player_reset   = 1'b0;
    tile_reset     = 1'b0;
    draw_stage     = 1'b0;
    draw_explosion = 1'b0;
    draw_bomb      = 1'b0;
    draw_p1        = 1'b0;
    draw_p1_hp     = 1'b0;
    draw_p2        = 1'b0;
    draw_p2_hp     = 1'b0;
    check_p1       = 1'b0;
    check_p2       = 1'b0;
    refresh        = 1'b0;
    print_screen   = 1'b0;
    copy_done      = 1'b0;

    // One pending tick is remembered until WAIT_TICK consumes it
    if (state == ST_WAIT_TICK) pend_n = tick_pend & tick;
    else                       pend_n = tick_pend | tick;

    // Shared LOAD -> GO -> WAIT handshake for every draw state
    copy_state = state inside {ST_STAGE, ST_TILES, ST_BOMBS, ST_DRAW_P1, ST_HP_P1,
                               ST_DRAW_P2, ST_HP_P2, ST_OVER};
    load       = copy_state && (phase == PH_LOAD);
    if (copy_state) begin
      case (phase)
        PH_LOAD: phase_n = PH_GO;
        PH_GO: begin
          copy_enable = 1'b1;
          phase_n     = PH_WAIT;
        end
        default: begin
          if (finished) begin
            copy_done = 1'b1;
            phase_n   = PH_LOAD;
          end
        end
      endcase
    end

    case (state)
      ST_IDLE: begin
        if (start) begin
          player_reset = 1'b1;
          tile_reset   = 1'b1;
          winner_n     = WIN_NONE;
          state_n      = ST_STAGE;
        end
      end
      ST_STAGE: begin
        memory_select = MEM_STAGE;
        draw_stage    = load;
        if (copy_done) state_n = ST_TILES;
      end
      ST_TILES: begin
        memory_select  = MEM_TILE;
        draw_explosion = load;
        if (copy_done) state_n = ST_TC_STEP;
      end
      ST_TC_STEP: begin
        memory_select = MEM_TILE;
        tc_enable     = 1'b1;
        state_n       = ST_TC_CHECK;
      end
      ST_TC_CHECK: begin
        // Counters back at 0 after an advance means the whole field wrapped
        memory_select = MEM_TILE;
        state_n       = all_tiles_drawn ? ST_BOMBS : ST_TILES;
      end
      ST_BOMBS: begin
        memory_select = MEM_TILE;
        draw_bomb     = load;
        if (copy_done) begin
          if (bomb_id == LAST_BOMB) begin
            bomb_n  = '0;
            state_n = ST_CHK_P1;
          end else begin
            bomb_n = bomb_id + 3'd1;
          end
        end
      end
      ST_CHK_P1, ST_CHK_P2: begin
        // Hold each corner long enough for the registered tile lookup, gap one cycle between
        check_p1 = (state == ST_CHK_P1) && !chk_gap;
        check_p2 = (state == ST_CHK_P2) && !chk_gap;
        if (chk_gap) begin
          gap_n    = 1'b0;
          corner_n = corner_id + 2'd1;
        end else if (hold_cnt == LAST_HOLD) begin
          hold_n = '0;
          if (corner_id == 2'd3) begin
            corner_n = '0;
            state_n  = (state == ST_CHK_P1) ? ST_DRAW_P1 : ST_DRAW_P2;
          end else begin
            gap_n = 1'b1;
          end
        end else begin
          hold_n = hold_cnt + 8'd1;
        end
      end
      ST_DRAW_P1: begin
        memory_select = MEM_SPRITE;
        draw_p1       = load;
        if (copy_done) state_n = (p1_lives == 2'd0) ? ST_CHK_P2 : ST_HP_P1;
      end
      ST_HP_P1: begin
        memory_select = MEM_SPRITE;
        draw_p1_hp    = load;
        if (copy_done) begin
          // >= rather than == so a life lost mid-row still terminates
          if (({1'b0, p1_hp_id} + 3'd1) >= {1'b0, p1_lives}) begin
            hp1_n   = '0;
            state_n = ST_CHK_P2;
          end else begin
            hp1_n = p1_hp_id + 2'd1;
          end
        end
      end
      ST_DRAW_P2: begin
        memory_select = MEM_SPRITE;
        draw_p2       = load;
        if (copy_done) state_n = (p2_lives == 2'd0) ? ST_COMMIT : ST_HP_P2;
      end
      ST_HP_P2: begin
        memory_select = MEM_SPRITE;
        draw_p2_hp    = load;
        if (copy_done) begin
          if (({1'b0, p2_hp_id} + 3'd1) >= {1'b0, p2_lives}) begin
            hp2_n   = '0;
            state_n = ST_COMMIT;
          end else begin
            hp2_n = p2_hp_id + 2'd1;
          end
        end
      end
      ST_COMMIT: begin
        print_screen = 1'b1;
        state_n      = ST_WAIT_TICK;
      end
      ST_WAIT_TICK: begin
        // Lives are only judged here so a frame always completes
        if (tick || tick_pend) begin
          refresh = 1'b1;
          if (p1_lives == 2'd0 || p2_lives == 2'd0) begin
            winner_n = winner_code(p1_lives, p2_lives);
            state_n  = ST_OVER;
          end else begin
            state_n = ST_STAGE;
          end
        end
      end
      ST_OVER: begin
        memory_select = MEM_GAMEOVER;
        draw_stage    = load;
        if (copy_done) state_n = ST_OVER_COMMIT;
      end
      ST_OVER_COMMIT: begin
        memory_select = MEM_GAMEOVER;
        print_screen  = 1'b1;
        state_n       = ST_WAITREL;
      end
      ST_WAITREL: begin
        if (!start) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State, handshake phase, item indices and winner registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      phase     <= PH_LOAD;
      bomb_id   <= '0;
      corner_id <= '0;
      p1_hp_id  <= '0;
      p2_hp_id  <= '0;
      hold_cnt  <= '0;
      chk_gap   <= 1'b0;
      tick_pend <= 1'b0;
      winner    <= WIN_NONE;
    end else begin
      state     <= state_n;
      phase     <= phase_n;
      bomb_id   <= bomb_n;
      corner_id <= corner_n;
      p1_hp_id  <= hp1_n;
      p2_hp_id  <= hp2_n;
      hold_cnt  <= hold_n;
      chk_gap   <= gap_n;
      tick_pend <= pend_n;
      winner    <= winner_n;
    end
  end

endmodule

// File: tb/tb_bomberman_control.sv
// Directed bench for the frame scheduler with a copy-engine and tile-counter model.
// Latency: copy engine answers finished 5 cycles after each copy_enable.
// Backpressure: the model flags any copy_enable issued while a copy is outstanding.
module tb_bomberman_control;
  import bomberman_pkg::*;

  localparam int FC       = 20;
  localparam int NB       = 8;
  localparam int CH       = 3;
  localparam int COPY_LAT = 5;
  localparam int NTILES   = TILES_PER_SIDE * TILES_PER_SIDE;

  // per-frame accumulator slots
  localparam int K_EXPL = 0, K_TC = 1, K_BOMB = 2, K_BBAD = 3, K_C1 = 4, K_SEQ1 = 5,
                 K_HP1 = 6, K_H1BAD = 7, K_C2 = 8, K_SEQ2 = 9, K_HP2 = 10, K_H2BAD = 11,
                 K_P1 = 12, K_P2 = 13, NK = 14;

  logic       clock = 1'b0;
  logic       reset, start, finished, all_tiles_drawn;
  logic [1:0] p1_lives, p2_lives;
  logic       copy_enable, tc_enable, player_reset, tile_reset;
  logic       draw_stage, draw_explosion, draw_bomb, draw_p1, draw_p1_hp, draw_p2, draw_p2_hp;
  logic       check_p1, check_p2, refresh, print_screen;
  logic [1:0] memory_select, corner_id, p1_hp_id, p2_hp_id, winner;
  logic [2:0] bomb_id;
  logic [14:0] strobes;

  int n_checks = 0;
  int n_fail   = 0;

  int acc [NK];
  int last [NK];
  int cd, tile_cnt, viol, n_copy, n_refresh, n_preset, frames_done, since_print, last_gap;
  logic [1:0] rec_msel, stage_msel;
  logic c1_prev, c2_prev, draw_prev;
  int snap;

  bomberman_control #(
    .FRAME_CYCLES (FC),
    .NUM_BOMBS    (NB),
    .CHECK_HOLD   (CH)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .finished        (finished),
    .all_tiles_drawn (all_tiles_drawn),
    .p1_lives        (p1_lives),
    .p2_lives        (p2_lives),
    .copy_enable     (copy_enable),
    .memory_select   (memory_select),
    .tc_enable       (tc_enable),
    .player_reset    (player_reset),
    .tile_reset      (tile_reset),
    .draw_stage      (draw_stage),
    .draw_explosion  (draw_explosion),
    .draw_bomb       (draw_bomb),
    .draw_p1         (draw_p1),
    .draw_p1_hp      (draw_p1_hp),
    .draw_p2         (draw_p2),
    .draw_p2_hp      (draw_p2_hp),
    .check_p1        (check_p1),
    .check_p2        (check_p2),
    .corner_id       (corner_id),
    .bomb_id         (bomb_id),
    .p1_hp_id        (p1_hp_id),
    .p2_hp_id        (p2_hp_id),
    .refresh         (refresh),
    .print_screen    (print_screen),
    .winner          (winner)
  );

  assign strobes = {copy_enable, tc_enable, player_reset, tile_reset, draw_stage,
                    draw_explosion, draw_bomb, draw_p1, draw_p1_hp, draw_p2, draw_p2_hp,
                    check_p1, check_p2, refresh, print_screen};

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Bounded wait for the model to have seen a given number of print_screen pulses
  task automatic wait_frames(input int target, input int budget, input string tag);
    int i = 0;
    while (frames_done < target && i < budget) begin
      @(posedge clock);
      i++;
    end
    check(tag, 32'(frames_done >= target), 1);
  endtask

  // corner order 0,1,2,3 shifted in two bits at a time gives 27
  task automatic check_frame(input int hp1_exp, input int hp2_exp);
    check("tiles_expl", last[K_EXPL], NTILES);
    check("tiles_tc", last[K_TC], NTILES);
    check("bombs", last[K_BOMB], NB);
    check("bomb_ids", last[K_BBAD], 0);
    check("chk_p1_cycles", last[K_C1], 4 * CH);
    check("chk_p1_corners", last[K_SEQ1], 27);
    check("draw_p1", last[K_P1], 1);
    check("hp_p1", last[K_HP1], hp1_exp);
    check("hp_p1_ids", last[K_H1BAD], 0);
    check("chk_p2_cycles", last[K_C2], 4 * CH);
    check("chk_p2_corners", last[K_SEQ2], 27);
    check("draw_p2", last[K_P2], 1);
    check("hp_p2", last[K_HP2], hp2_exp);
    check("hp_p2_ids", last[K_H2BAD], 0);
  endtask

  // Copy engine, tile counters and per-frame statistics, sampled on the falling edge
  initial begin
    finished = 1'b0; all_tiles_drawn = 1'b1;
    cd = 0; tile_cnt = 0; viol = 0; n_copy = 0; n_refresh = 0; n_preset = 0;
    frames_done = 0; since_print = 0; last_gap = -1;
    rec_msel = '0; stage_msel = '0; c1_prev = 1'b0; c2_prev = 1'b0; draw_prev = 1'b0;
    for (int k = 0; k < NK; k++) begin acc[k] = 0; last[k] = 0; end
    forever begin
      @(negedge clock);
      since_print++;
      finished = 1'b0;
      if (cd > 0) begin
        if (memory_select !== rec_msel) viol++;
        if (copy_enable) viol++;
        cd--;
        if (cd == 0) finished = 1'b1;
      end else if (copy_enable) begin
        if (!draw_prev) viol++;
        cd       = COPY_LAT;
        rec_msel = memory_select;
        n_copy++;
      end
      if (tile_reset)     tile_cnt = 0;
      else if (tc_enable) tile_cnt = (tile_cnt + 1) % NTILES;
      all_tiles_drawn = (tile_cnt == 0);

      if (draw_explosion) acc[K_EXPL]++;
      if (tc_enable) acc[K_TC]++;
      if (draw_bomb) begin
        if (int'(bomb_id) != acc[K_BOMB]) acc[K_BBAD]++;
        acc[K_BOMB]++;
      end
      if (check_p1) acc[K_C1]++;
      if (check_p1 && !c1_prev) acc[K_SEQ1] = acc[K_SEQ1] * 4 + int'(corner_id);
      if (check_p2) acc[K_C2]++;
      if (check_p2 && !c2_prev) acc[K_SEQ2] = acc[K_SEQ2] * 4 + int'(corner_id);
      if (draw_p1) acc[K_P1]++;
      if (draw_p2) acc[K_P2]++;
      if (draw_p1_hp) begin
        if (int'(p1_hp_id) != acc[K_HP1]) acc[K_H1BAD]++;
        acc[K_HP1]++;
      end
      if (draw_p2_hp) begin
        if (int'(p2_hp_id) != acc[K_HP2]) acc[K_H2BAD]++;
        acc[K_HP2]++;
      end
      if (draw_stage) stage_msel = memory_select;
      if (player_reset) n_preset++;
      if (refresh) begin
        n_refresh++;
        last_gap = since_print;
      end
      if (print_screen) begin
        for (int k = 0; k < NK; k++) begin last[k] = acc[k]; acc[k] = 0; end
        since_print = 0;
        frames_done++;
      end
      c1_prev   = check_p1;
      c2_prev   = check_p2;
      draw_prev = draw_stage | draw_explosion | draw_bomb | draw_p1 | draw_p1_hp |
                  draw_p2 | draw_p2_hp;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got 0 expected 1");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; p1_lives = 2'd3; p2_lives = 2'd3;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_strobes", 32'(strobes), 0);
    check("rst_msel", 32'(memory_select), 0);
    check("rst_ids", 32'({corner_id, bomb_id, p1_hp_id, p2_hp_id}), 0);
    check("rst_winner", 32'(winner), 0);

    // Start pulse: restart strobes, then stage LOAD, then copy GO
    @(posedge clock); #1 reset = 1'b0;
    @(posedge clock); #1 start = 1'b1;
    @(negedge clock);
    check("start_player_reset", 32'(player_reset), 1);
    check("start_tile_reset", 32'(tile_reset), 1);
    @(posedge clock); #1 start = 1'b0;
    @(negedge clock);
    check("stage_load", 32'(draw_stage), 1);
    check("stage_msel", 32'(memory_select), 0);
    check("player_reset_once", 32'(player_reset), 0);
    @(negedge clock);
    check("stage_go", 32'(copy_enable), 1);
    check("stage_go_strobe_off", 32'(draw_stage), 0);

    // Full frames with lives 3/3
    wait_frames(1, 3000, "frame1_timeout");
    check_frame(3, 3);
    wait_frames(3, 6000, "frame3_timeout");
    check_frame(3, 3);
    repeat (30) @(posedge clock);
    check("refresh_count", n_refresh, 3);
    check("refresh_after_commit", last_gap, 1);

    // P2 dies mid-field; start held high must be ignored outside IDLE
    #1 p2_lives = 2'd0; start = 1'b1;
    wait_frames(4, 3000, "frame4_timeout");
    check_frame(3, 0);
    check("refresh_before_over", n_refresh, 3);
    wait_frames(5, 300, "over_timeout");
    check("winner_p1", 32'(winner), 1);
    check("over_msel", 32'(stage_msel), 3);
    check("refresh_total", n_refresh, 4);
    snap = n_copy;
    repeat (20) @(posedge clock);
    check("waitrel_no_copy", n_copy, snap);
    check("waitrel_no_restart", n_preset, 1);
    check("waitrel_no_print", frames_done, 5);

    // Release start, then restart from IDLE
    #1 start = 1'b0;
    @(posedge clock);
    @(posedge clock); #1 p2_lives = 2'd3; start = 1'b1;
    @(negedge clock);
    check("restart_player_reset", 32'(player_reset), 1);
    @(posedge clock); #1 start = 1'b0;
    @(negedge clock);
    check("restart_winner_clear", 32'(winner), 0);
    check("restart_stage_load", 32'(draw_stage), 1);
    @(negedge clock);
    check("restart_go", 32'(copy_enable), 1);

    // Reset during the copy wait; the late finished must not provoke anything
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    check("midcopy_rst_strobes", 32'(strobes), 0);
    check("midcopy_rst_msel", 32'(memory_select), 0);
    snap = n_copy;
    repeat (20) @(posedge clock);
    @(negedge clock);
    check("late_finished_no_copy", n_copy, snap);
    check("late_finished_idle", 32'(strobes), 0);
    check("copy_protocol_violations", viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
